// File: rtl/lcv_mul_acc_arb.sv
// Round-robin arbiter sharing one pipelined signed MAC (a*b + c + d) among NUM_REQ requesters,
// with per-requester accumulators and an in-order response FIFO. Define LCV_MUL_ACC_ARB_SAT_EN to saturate results.
module lcv_mul_acc_arb #(
  parameter int NUM_REQ    = 4,
  parameter int LAT        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*16-1:0]      req_a,
  input  logic [NUM_REQ*16-1:0]      req_b,
  input  logic [NUM_REQ*33-1:0]      req_c,
  input  logic [NUM_REQ-1:0]         req_acc,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [32:0]                rsp_data
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;

  // Handshakes: op i issues on the edge where req_valid[i] & req_ready[i]; the FIFO head
  // pops on the edge where rsp_valid & rsp_ready. Requesters hold operands stable until granted.

  logic [ID_W-1:0]    r_ptr;
  logic [32:0]        r_acc    [NUM_REQ];
  logic               r_s_vld  [LAT];
  logic [ID_W-1:0]    r_s_id   [LAT];
  logic [15:0]        r_s_a    [LAT];
  logic [15:0]        r_s_b    [LAT];
  logic [32:0]        r_s_c    [LAT];
  logic [32:0]        r_s_d    [LAT];
  logic [ID_W-1:0]    r_f_id   [FIFO_DEPTH];
  logic [32:0]        r_f_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_inflight;

  logic [NUM_REQ-1:0] w_busy;
  logic [NUM_REQ-1:0] w_elig;
  logic               w_space;
  logic               w_found;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [15:0]        w_a_arr [NUM_REQ];
  logic [15:0]        w_b_arr [NUM_REQ];
  logic [32:0]        w_c_arr [NUM_REQ];
  logic [15:0]        w_sel_a;
  logic [15:0]        w_sel_b;
  logic [32:0]        w_sel_c;
  logic [32:0]        w_sel_d;
  logic signed [31:0] w_prod;
  logic [35:0]        w_sum;
  logic [32:0]        w_result;

  // A requester is busy while any of its ops sits in the MAC pipe.
  always_comb begin
    w_busy = '0;
    for (int s = 0; s < LAT; s++) begin
      if (r_s_vld[s]) w_busy[r_s_id[s]] = 1'b1;
    end
  end

  assign w_space = (r_cnt + r_inflight) < CNT_W'(FIFO_DEPTH);
  assign w_elig  = req_valid & ~(req_acc & w_busy) & {NUM_REQ{w_space}};

  always_comb begin
    logic [ID_W:0] v_sum;
    v_sum     = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (v_sum >= (ID_W+1)'(NUM_REQ)) v_sum = v_sum - (ID_W+1)'(NUM_REQ);
      if (!w_found && w_elig[v_sum[ID_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = v_sum[ID_W-1:0];
      end
    end
  end

  assign w_issue   = w_found & ~rst;
  assign w_ptr_nxt = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

  always_comb begin
    req_ready = '0;
    if (w_issue) req_ready[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_a_arr[i] = req_a[16*i +: 16];
      w_b_arr[i] = req_b[16*i +: 16];
      w_c_arr[i] = req_c[33*i +: 33];
    end
  end

  assign w_sel_a = w_a_arr[w_gnt_idx];
  assign w_sel_b = w_b_arr[w_gnt_idx];
  assign w_sel_c = w_c_arr[w_gnt_idx];
  assign w_sel_d = req_acc[w_gnt_idx] ? r_acc[w_gnt_idx] : '0;

  assign w_prod = $signed(r_s_a[LAT-1]) * $signed(r_s_b[LAT-1]);
  assign w_sum  = {{4{w_prod[31]}}, w_prod}
                + {{3{r_s_c[LAT-1][32]}}, r_s_c[LAT-1]}
                + {{3{r_s_d[LAT-1][32]}}, r_s_d[LAT-1]};

`ifdef LCV_MUL_ACC_ARB_SAT_EN
  // The sum fits in 33 signed bits exactly when its top four bits agree; otherwise clamp by sign.
  always_comb begin
    if (w_sum[35:32] == 4'b0000 || w_sum[35:32] == 4'b1111) w_result = w_sum[32:0];
    else if (w_sum[35])                                     w_result = 33'h1_0000_0000;
    else                                                    w_result = 33'h0_FFFF_FFFF;
  end
`else
  assign w_result = w_sum[32:0];
`endif

  assign w_push = r_s_vld[LAT-1];
  assign w_pop  = rsp_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_inflight <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_acc[i] <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_s_vld[s] <= 1'b0;
        r_s_id[s]  <= '0;
      end
    end else begin
      if (w_issue) r_ptr <= w_ptr_nxt;
      r_s_vld[0] <= w_issue;
      if (w_issue) r_s_id[0] <= w_gnt_idx;
      for (int s = 1; s < LAT; s++) begin
        r_s_vld[s] <= r_s_vld[s-1];
        r_s_id[s]  <= r_s_id[s-1];
      end
      if (w_push) begin
        r_wr                 <= r_wr + PTR_W'(1);
        r_acc[r_s_id[LAT-1]] <= w_result;
      end
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_W'(1);
      if (w_issue && !w_push)      r_inflight <= r_inflight + CNT_W'(1);
      else if (!w_issue && w_push) r_inflight <= r_inflight - CNT_W'(1);
    end
  end

  // Operand pipe and FIFO storage need no reset: their valid bits and counters gate every use.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_s_a[0] <= w_sel_a;
      r_s_b[0] <= w_sel_b;
      r_s_c[0] <= w_sel_c;
      r_s_d[0] <= w_sel_d;
    end
    for (int s = 1; s < LAT; s++) begin
      r_s_a[s] <= r_s_a[s-1];
      r_s_b[s] <= r_s_b[s-1];
      r_s_c[s] <= r_s_c[s-1];
      r_s_d[s] <= r_s_d[s-1];
    end
    if (w_push && !rst) begin
      r_f_id[r_wr]   <= r_s_id[LAT-1];
      r_f_data[r_wr] <= w_result;
    end
  end

  assign rsp_valid = (r_cnt != '0);
  assign rsp_id    = rsp_valid ? r_f_id[r_rd]   : '0;
  assign rsp_data  = rsp_valid ? r_f_data[r_rd] : '0;

endmodule

// File: tb/tb_lcv_mul_acc_arb.sv
// Directed bench for lcv_mul_acc_arb: grants push hand-computed responses into a queue,
// and an independent monitor pops and compares every accepted FIFO head.
module tb_lcv_mul_acc_arb;
  localparam int NUM_REQ    = 4;
  localparam int LAT        = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W       = 2;

`ifdef LCV_MUL_ACC_ARB_SAT_EN
  localparam logic [32:0] T5A_EXP = 33'h0_FFFF_FFFF;
  localparam logic [32:0] T5B_EXP = 33'h1_0000_0000;
`else
  localparam logic [32:0] T5A_EXP = 33'h1_3FFF_FFFF;
  localparam logic [32:0] T5B_EXP = 33'h0_C000_8000;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*16-1:0] req_a = '0;
  logic [NUM_REQ*16-1:0] req_b = '0;
  logic [NUM_REQ*33-1:0] req_c = '0;
  logic [NUM_REQ-1:0]    req_acc = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [ID_W-1:0]       rsp_id;
  logic [32:0]           rsp_data;

  logic [ID_W+32:0]      exp_q[$];
  logic [NUM_REQ-1:0]    rdy_log[$];
  logic [32:0]           stream_exp [NUM_REQ];
  logic [ID_W+32:0]      mon_exp;
  int                    n_checks = 0;
  int                    n_pass   = 0;
  int                    w;
  int                    g;

  lcv_mul_acc_arb #(.NUM_REQ(NUM_REQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_acc(req_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation timed out");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp", 64'({rsp_id, rsp_data}), 64'(mon_exp));
      end
    end
  end

  // Driver tasks
  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [32:0] c, input logic acc);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_c[33*i +: 33] = c;
    req_acc[i]        = acc;
  endtask

  task automatic issue_one(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [32:0] c, input logic acc, input logic [32:0] exp,
                           output int waits);
    logic got;
    set_op(i, a, b, c, acc);
    req_valid[i] = 1'b1;
    waits = 0;
    got   = 1'b0;
    while (!got && waits < 50) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
      else waits++;
    end
    if (got) exp_q.push_back({ID_W'(i), exp});
    else check("grant_timeout", 64'(req_ready[i]), 64'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic run_stream(input int n, output int grants);
    grants = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rdy_log.push_back(req_ready);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          exp_q.push_back({ID_W'(i), stream_exp[i]});
          grants++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("drain_idle", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single op, granted the same cycle, result after LAT edges
    issue_one(0, 16'sd3, -16'sd4, 33'sd5, 1'b0, -33'sd7, w);
    check("t1_ready_same_cycle", 64'(w), 64'd0);
    @(negedge clk);
    check("t1_not_yet", 64'(rsp_valid), 64'd0);
    repeat (LAT - 1) @(negedge clk);
    @(negedge clk);
    check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t1_rsp_id", 64'(rsp_id), 64'd0);
    drain();

    // 2: all requesters valid, round-robin from pointer 0
    do_reset();
    stream_exp = '{33'd10, 33'd21, 33'd32, 33'd43};
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 16'(i + 1), 16'sd10, 33'(i), 1'b0);
    rsp_ready = 1'b1;
    req_valid = '1;
    rdy_log.delete();
    run_stream(8, g);
    req_valid = '0;
    for (int k = 0; k < 8; k++) check("t2_grant_order", 64'(rdy_log[k]), 64'(4'b0001 << (k % 4)));
    drain();

    // 3: accumulate hazard stall on requester 2
    issue_one(2, 16'sd2, 16'sd3, 33'sd0, 1'b0, 33'sd6, w);
    check("t3_first_wait", 64'(w), 64'd0);
    issue_one(2, 16'sd2, 16'sd3, 33'sd0, 1'b1, 33'sd12, w);
    check("t3_stall_wait", 64'(w), 64'(LAT));
    drain();

    // 4: backpressure fills FIFO, then resumes after pops
    stream_exp = '{-33'sd293, -33'sd593, -33'sd893, -33'sd1193};
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 16'(100 * (i + 1)), -16'sd3, 33'sd7, 1'b0);
    rsp_ready = 1'b0;
    req_valid = '1;
    rdy_log.delete();
    run_stream(10, g);
    check("t4_issues", 64'(g), 64'd4);
    check("t4_ready_idle", 64'(rdy_log[9]), 64'd0);
    rsp_ready = 1'b1;
    rdy_log.delete();
    run_stream(6, g);
    req_valid = '0;
    check("t4_resume_first", 64'(rdy_log[0]), 64'd0);
    check("t4_resume_grants", 64'(g), 64'd5);
    drain();

    // 5: overflow boundaries and accumulator chaining
    issue_one(3, 16'h8000, 16'h8000, 33'h0_FFFF_FFFF, 1'b0, T5A_EXP, w);
    issue_one(3, 16'sd0, 16'sd0, 33'sd0, 1'b1, T5A_EXP, w);
    issue_one(0, 16'h8000, 16'h7FFF, 33'h1_0000_0000, 1'b0, T5B_EXP, w);
    issue_one(1, -16'sd5, 16'sd7, -33'sd100, 1'b0, -33'sd135, w);
    issue_one(1, 16'sd2, -16'sd8, 33'sd3, 1'b1, -33'sd148, w);
    drain();

    // 6: reset with work in the FIFO and pipe
    rsp_ready = 1'b0;
    issue_one(1, 16'sd10, 16'sd10, 33'sd0, 1'b0, 33'sd100, w);
    issue_one(0, 16'sd1, 16'sd1, 33'sd0, 1'b0, 33'sd1, w);
    issue_one(2, 16'sd2, 16'sd2, 33'sd0, 1'b0, 33'sd4, w);
    do_reset();
    @(negedge clk);
    check("t6_flushed", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue_one(1, 16'sd3, 16'sd4, 33'sd5, 1'b1, 33'sd17, w);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
